// File: rtl/gate_sweep_checker.sv
// Stimulus-and-response engine for a 2-input gate: sweeps {a,b} through 00..11,
// samples y after a settle window and scores it against a latched truth table.
module gate_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,  // 1..255
    parameter int unsigned PASSES        = 1   // 1..255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [3:0] exp_tt_i,
    input  logic       y_i,
    output logic       a_o,
    output logic       b_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [7:0] err_count_o,
    output logic       first_fail_valid_o,
    output logic [1:0] first_fail_idx_o
);

    localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] PassLast   = 8'(PASSES - 1);

    typedef enum logic [1:0] {StIdle, StApply, StSample, StDone} state_e;

    state_e     state_q, state_d;
    logic [3:0] exp_q, exp_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] pcnt_q, pcnt_d;
    logic [7:0] settle_q, settle_d;
    logic [7:0] err_q, err_d;
    logic       ffv_q, ffv_d;
    logic [1:0] ffi_q, ffi_d;
    logic       pass_q, pass_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // State and result registers; synchronous reset abandons any run in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            exp_q    <= 4'd0;
            idx_q    <= 2'd0;
            pcnt_q   <= 8'd0;
            settle_q <= 8'd0;
            err_q    <= 8'd0;
            ffv_q    <= 1'b0;
            ffi_q    <= 2'd0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            idx_q    <= idx_d;
            pcnt_q   <= pcnt_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            ffv_q    <= ffv_d;
            ffi_q    <= ffi_d;
            pass_q   <= pass_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state: sweep sequencing, settle timing and mismatch scoring.
    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        idx_d    = idx_q;
        pcnt_d   = pcnt_q;
        settle_d = settle_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        ffi_d    = ffi_q;
        pass_d   = pass_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    exp_d    = exp_tt_i;
                    err_d    = 8'd0;
                    pass_d   = 1'b0;
                    ffv_d    = 1'b0;
                    ffi_d    = 2'd0;
                    idx_d    = 2'd0;
                    pcnt_d   = 8'd0;
                    settle_d = 8'd0;
                    busy_d   = 1'b1;
                    state_d  = StApply;
                end
            end
            StApply: begin
                if (settle_q == SettleLast) begin
                    settle_d = 8'd0;
                    state_d  = StSample;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            StSample: begin
                if (y_i != exp_q[idx_q]) begin
                    if (err_q != 8'hff) begin
                        err_d = err_q + 8'd1;
                    end
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffi_d = idx_q;
                    end
                end
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = StApply;
                end else if (pcnt_q != PassLast) begin
                    idx_d   = 2'd0;
                    pcnt_d  = pcnt_q + 8'd1;
                    state_d = StApply;
                end else begin
                    // idx returns to 0 so a/b drop to 00 in the DONE cycle
                    idx_d   = 2'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 8'd0);
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // a/b come straight from the registered vector index.
    always_comb begin
        a_o                = idx_q[1];
        b_o                = idx_q[0];
        busy_o             = busy_q;
        done_o             = done_q;
        pass_o             = pass_q;
        err_count_o        = err_q;
        first_fail_valid_o = ffv_q;
        first_fail_idx_o   = ffi_q;
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: a default-parameter instance scored against a
// truth-table model, plus a PASSES=70 instance for count saturation.
module tb_gate_sweep_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start_l = 1'b0;
    logic [3:0] exp_tt = 4'd0;
    logic [3:0] gate_tt = 4'd0;

    logic       y, a, b, busy, done, pass, ffv;
    logic [7:0] err;
    logic [1:0] ffi;

    logic       y_l, a_l, b_l, busy_l, done_l, pass_l, ffv_l;
    logic [7:0] err_l;
    logic [1:0] ffi_l;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Gate under test modelled as a truth table indexed by {a,b}.
    assign y   = gate_tt[{a, b}];
    // Long instance sees a gate that is always the inverse of what is expected.
    assign y_l = ~exp_tt[{a_l, b_l}];

    gate_sweep_checker #(.SETTLE_CYCLES(2), .PASSES(1)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .exp_tt_i(exp_tt), .y_i(y),
        .a_o(a), .b_o(b), .busy_o(busy), .done_o(done), .pass_o(pass),
        .err_count_o(err), .first_fail_valid_o(ffv), .first_fail_idx_o(ffi)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(2), .PASSES(70)) u_dut_long (
        .clk_i(clk), .rst_i(rst), .start_i(start_l), .exp_tt_i(exp_tt), .y_i(y_l),
        .a_o(a_l), .b_o(b_l), .busy_o(busy_l), .done_o(done_l), .pass_o(pass_l),
        .err_count_o(err_l), .first_fail_valid_o(ffv_l), .first_fail_idx_o(ffi_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected results from the truth tables alone: every differing bit is a
    // mismatch per pass, first failure is the lowest differing vector.
    task automatic model(input logic [3:0] gtt, input logic [3:0] ett, input int passes,
                         output int e_err, output bit e_ffv, output int e_ffi);
        logic [3:0] diff;
        int n;
        diff  = gtt ^ ett;
        n     = 0;
        e_ffv = 1'b0;
        e_ffi = 0;
        for (int i = 0; i < 4; i++) begin
            if (diff[i]) begin
                if (!e_ffv) e_ffi = i;
                e_ffv = 1'b1;
                n++;
            end
        end
        e_err = n * passes;
        if (e_err > 255) e_err = 255;
    endtask

    // One run on the short instance. Called away from the clock edge.
    // re_k: cycle index after which start is re-pulsed (-1 none);
    // rst_k: cycle index at which reset has taken effect (-1 none).
    task automatic run_short(input string tag, input logic [3:0] gtt, input logic [3:0] ett,
                             input int re_k, input int rst_k);
        int  e_err, e_ffi;
        bit  e_ffv;
        model(gtt, ett, 1, e_err, e_ffv, e_ffi);
        gate_tt = gtt;
        exp_tt  = ett;
        start   = 1'b1;
        @(posedge clk);  // E0
        #1;
        start  = 1'b0;
        exp_tt = ~ett;  // must already be latched
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (k == rst_k) begin
                rst = 1'b0;
                check({tag, " rst busy"}, busy, 0);
                check({tag, " rst ab"}, {a, b}, 0);
                check({tag, " rst err"}, err, 0);
                check({tag, " rst done"}, done, 0);
                check({tag, " rst ffv"}, ffv, 0);
                check({tag, " rst pass"}, pass, 0);
                for (int j = 0; j < 8; j++) begin
                    @(posedge clk);
                    #1;
                    check({tag, " no done after rst"}, {done, busy}, 0);
                end
                return;
            end
            check({tag, " busy"}, busy, (k < 12) ? 1 : 0);
            check({tag, " done"}, done, (k == 12) ? 1 : 0);
            check({tag, " ab"}, {a, b}, (k < 12) ? k / 3 : 0);
            if (k == re_k - 1) start = 1'b1;
            if (k == re_k) start = 1'b0;
            if (k == rst_k - 1) rst = 1'b1;
        end
        check({tag, " err"}, err, e_err);
        check({tag, " pass"}, pass, (e_err == 0) ? 1 : 0);
        check({tag, " ffv"}, ffv, e_ffv);
        check({tag, " ffi"}, ffi, e_ffi);
        @(posedge clk);
        #1;
        check({tag, " done one cycle"}, done, 0);
        check({tag, " err held"}, err, e_err);
        check({tag, " pass held"}, pass, (e_err == 0) ? 1 : 0);
        @(negedge clk);
    endtask

    initial begin
        int  cyc;
        bit  seen;
        logic [3:0] rg, re;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset ab", {a, b}, 0);
        check("reset done", done, 0);
        check("reset pass", pass, 0);
        check("reset err", err, 0);
        check("reset ffv", ffv, 0);
        check("reset ffi", ffi, 0);
        check("reset long busy", busy_l, 0);
        rst = 1'b0;
        @(negedge clk);

        run_short("and", 4'b1000, 4'b1000, -1, -1);
        run_short("tie0", 4'b0000, 4'b1000, -1, -1);
        run_short("nand", 4'b0111, 4'b1000, -1, -1);
        run_short("nand ok", 4'b0111, 4'b0111, -1, -1);
        run_short("restart", 4'b0110, 4'b1000, 5, -1);
        run_short("midrst", 4'b0110, 4'b1000, -1, 7);
        @(negedge clk);
        run_short("after rst", 4'b1110, 4'b1110, -1, -1);

        for (int r = 0; r < 10; r++) begin
            rg = 4'($urandom_range(0, 15));
            re = ($urandom_range(0, 2) == 0) ? rg : 4'($urandom_range(0, 15));
            run_short($sformatf("rand%0d", r), rg, re, -1, -1);
        end

        // Saturation on the 70-pass instance.
        exp_tt  = 4'b1000;
        start_l = 1'b1;
        @(posedge clk);  // E0
        #1;
        start_l = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 2000) begin
            if (done_l) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        check("long done seen", seen, 1);
        check("long done cycle", cyc, 840);
        check("long err sat", err_l, 255);
        check("long pass", pass_l, 0);
        check("long ffv", ffv_l, 1);
        check("long ffi", ffi_l, 0);
        check("long busy", busy_l, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
